sine_seq: RTL and testbench

- Sequencer that drives the existing 512-entry quarter-wave sine difference ROM. The ROM has a 9-bit address in, a 16-bit combinational unsigned difference out, and is not instantiated here.
- Walks the ROM address forward and backward per quadrant and adds or subtracts the returned difference into a signed accumulator, reconstructing a full-period sine one sample per tick.
- Sits between the sample-rate tick generator and the DAC/output formatter. Start/stop control comes from the host register block.

---
 rtl/sine_pkg.sv | 23 ++
 rtl/sine_seq_if.sv | 32 +++
 rtl/sine_seq.sv | 132 +++++++++++++
 tb/tb_sine_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared types and default widths for the quarter-wave sine sequencer.
package sine_pkg;

    localparam int ADRS_W_DEF = 9;
    localparam int DIFF_W_DEF = 16;
    localparam int ACC_W_DEF  = 18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_Q0,
        ST_Q1,
        ST_Q2,
        ST_Q3
    } state_e;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

endpackage

// File: rtl/sine_seq_if.sv
// Control, ROM and sample signals between the sequencer and its neighbours.
interface sine_seq_if
    import sine_pkg::*;
#(
    parameter int ADRS_W = ADRS_W_DEF,
    parameter int DIFF_W = DIFF_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);
    logic                     start;
    logic                     stop;
    logic                     tick;
    logic [ADRS_W-1:0]        rom_adrs;
    logic [DIFF_W-1:0]        rom_diff;
    logic signed [ACC_W-1:0]  sample;
    logic                     sample_vld;
    logic [1:0]               quadrant;
    logic                     busy;
    logic                     done;
    logic [15:0]              period_cnt;

    // master: host, tick source and ROM side
    modport master (
        output start, stop, tick, rom_diff,
        input  rom_adrs, sample, sample_vld, quadrant, busy, done, period_cnt
    );

    modport slave (
        input  start, stop, tick, rom_diff,
        output rom_adrs, sample, sample_vld, quadrant, busy, done, period_cnt
    );

endinterface

// File: rtl/sine_seq.sv
// Walks a quarter-wave difference ROM forward/backward per quadrant and
// integrates the differences into a signed full-period sine, one step per tick.
module sine_seq
    import sine_pkg::*;
#(
    parameter int ADRS_W = ADRS_W_DEF,
    parameter int DIFF_W = DIFF_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    sine_seq_if.slave bus
);

    localparam logic [ADRS_W-1:0] ADRS_MAX = '1;

    state_e                  state_q;
    quad_e                   quad_q;
    logic [ADRS_W-1:0]       adrs_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    vld_q;
    logic                    done_q;
    logic                    stop_pend_q;
    logic [15:0]             period_q;

    logic signed [ACC_W-1:0] diff_ext;
    logic signed [ACC_W-1:0] acc_inc_d;
    logic signed [ACC_W-1:0] acc_dec_d;
    logic                    adrs_at_max;
    logic                    adrs_at_zero;

    // ROM difference is unsigned: zero-extend before the signed add/subtract
    always_comb begin
        diff_ext     = signed'(ACC_W'(bus.rom_diff));
        acc_inc_d    = acc_q + diff_ext;
        acc_dec_d    = acc_q - diff_ext;
        adrs_at_max  = (adrs_q == ADRS_MAX);
        adrs_at_zero = (adrs_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            quad_q      <= QUAD_0;
            adrs_q      <= '0;
            acc_q       <= '0;
            vld_q       <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            period_q    <= '0;
        end else begin
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (bus.start) begin
                    state_q     <= ST_Q0;
                    quad_q      <= QUAD_0;
                    adrs_q      <= '0;
                    acc_q       <= '0;
                    period_q    <= '0;
                    stop_pend_q <= 1'b0;
                end
            end else begin
                if (bus.stop) begin
                    stop_pend_q <= 1'b1;
                end
                if (bus.tick) begin
                    vld_q <= 1'b1;
                    // The endpoint address is replayed on entry to the next
                    // quadrant, so the walk mirrors and acc closes at zero.
                    unique case (state_q)
                        ST_Q0: begin
                            acc_q <= acc_inc_d;
                            if (adrs_at_max) begin
                                state_q <= ST_Q1;
                                quad_q  <= QUAD_1;
                            end else begin
                                adrs_q <= adrs_q + ADRS_W'(1);
                            end
                        end
                        ST_Q1: begin
                            acc_q <= acc_dec_d;
                            if (adrs_at_zero) begin
                                state_q <= ST_Q2;
                                quad_q  <= QUAD_2;
                            end else begin
                                adrs_q <= adrs_q - ADRS_W'(1);
                            end
                        end
                        ST_Q2: begin
                            acc_q <= acc_dec_d;
                            if (adrs_at_max) begin
                                state_q <= ST_Q3;
                                quad_q  <= QUAD_3;
                            end else begin
                                adrs_q <= adrs_q + ADRS_W'(1);
                            end
                        end
                        ST_Q3: begin
                            acc_q <= acc_inc_d;
                            if (adrs_at_zero) begin
                                period_q <= period_q + 16'd1;
                                quad_q   <= QUAD_0;
                                if (stop_pend_q || bus.stop) begin
                                    state_q     <= ST_IDLE;
                                    done_q      <= 1'b1;
                                    stop_pend_q <= 1'b0;
                                end else begin
                                    state_q <= ST_Q0;
                                end
                            end else begin
                                adrs_q <= adrs_q - ADRS_W'(1);
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.rom_adrs   = adrs_q;
    assign bus.sample     = acc_q;
    assign bus.sample_vld = vld_q;
    assign bus.quadrant   = quad_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.period_cnt = period_q;

endmodule

// File: tb/tb_sine_seq.sv
// Self-checking bench for sine_seq: ROM model beside the DUT, closed-form
// expected waveform from prefix sums of the ROM contents.
module tb_sine_seq;
    import sine_pkg::*;

    localparam int AW   = 9;
    localparam int DW   = 16;
    localparam int SW   = 18;
    localparam int QLEN = 512;
    localparam int PLEN = 4 * QLEN;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sine_seq_if #(.ADRS_W(AW), .DIFF_W(DW), .ACC_W(SW)) bus ();

    logic [DW-1:0] rom_mem [0:QLEN-1];
    assign bus.rom_diff = rom_mem[bus.rom_adrs];

    sine_seq #(.ADRS_W(AW), .DIFF_W(DW), .ACC_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     checks   = 0;
    int     failures = 0;
    longint pref [0:QLEN];

    // ---------------- reference model ----------------
    // mode 0: all ones, 1: sampled sine quarter, 2: random differences
    task automatic load_rom(input int mode);
        real a0, a1;
        pref[0] = 0;
        for (int i = 0; i < QLEN; i++) begin
            case (mode)
                0: rom_mem[i] = 16'd1;
                1: begin
                    a0 = 60000.0 * $sin(3.14159265358979 * i / (2.0 * QLEN));
                    a1 = 60000.0 * $sin(3.14159265358979 * (i + 1) / (2.0 * QLEN));
                    rom_mem[i] = 16'(int'(a1) - int'(a0));
                end
                default: rom_mem[i] = 16'($urandom_range(0, 250));
            endcase
            pref[i+1] = pref[i] + longint'(rom_mem[i]);
        end
    endtask

    // Sample after k ticks since start: rise, fall, negative fall, negative rise.
    function automatic longint exp_sample(input int k);
        int p;
        p = k % PLEN;
        if (p <= QLEN)          return pref[p];
        else if (p <= 2 * QLEN) return pref[2 * QLEN - p];
        else if (p <= 3 * QLEN) return -pref[p - 2 * QLEN];
        else                    return -pref[PLEN - p];
    endfunction

    // Address presented to the ROM after k ticks (i.e. for tick k+1).
    function automatic int exp_adrs(input int k);
        int t, q, j;
        t = k % PLEN;
        q = t / QLEN;
        j = t % QLEN;
        return (q % 2 == 0) ? j : (QLEN - 1 - j);
    endfunction

    function automatic int exp_quad(input int k);
        return (k % PLEN) / QLEN;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick(input bit with_stop = 1'b0, input bit with_start = 1'b0);
        bus.tick  = 1'b1;
        bus.stop  = with_stop;
        bus.start = with_start;
        cyc();
        bus.tick  = 1'b0;
        bus.stop  = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic quiet_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.tick = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        checks++; if (bus.rom_adrs !== '0) begin failures++; $display("FAIL reset_adrs got %0d want 0", bus.rom_adrs); end
        checks++; if (bus.sample !== '0) begin failures++; $display("FAIL reset_sample got %0d want 0", bus.sample); end
        checks++; if (bus.sample_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got %b want 0", bus.sample_vld); end
        checks++; if (bus.quadrant !== 2'd0) begin failures++; $display("FAIL reset_quad got %0d want 0", bus.quadrant); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.period_cnt !== 16'd0) begin failures++; $display("FAIL reset_period got %0d want 0", bus.period_cnt); end
        // tick and stop are ignored while idle
        pulse_tick(1'b1, 1'b0);
        checks++; if (bus.sample_vld !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL idle_tick vld=%b busy=%b want 0 0", bus.sample_vld, bus.busy); end
        $display("scenario reset done");
    endtask

    task automatic test_const_rom();
        int bk [5] = '{1, 512, 1024, 1536, 2048};
        int bv [5] = '{1, 512, 0, -512, 0};
        quiet_reset();
        load_rom(0);
        do_start();
        checks++; if (bus.busy !== 1'b1 || bus.sample !== '0 || bus.sample_vld !== 1'b0) begin failures++; $display("FAIL const_start busy=%b sample=%0d vld=%b want 1 0 0", bus.busy, bus.sample, bus.sample_vld); end
        for (int k = 1; k <= PLEN; k++) begin
            checks++; if (int'(bus.rom_adrs) !== exp_adrs(k - 1)) begin failures++; $display("FAIL const_adrs k=%0d got %0d want %0d", k, bus.rom_adrs, exp_adrs(k - 1)); end
            pulse_tick();
            checks++; if (bus.sample_vld !== 1'b1) begin failures++; $display("FAIL const_vld k=%0d got %b want 1", k, bus.sample_vld); end
            checks++; if (longint'(bus.sample) !== exp_sample(k)) begin failures++; $display("FAIL const_sample k=%0d got %0d want %0d", k, bus.sample, exp_sample(k)); end
            checks++; if (int'(bus.quadrant) !== exp_quad(k)) begin failures++; $display("FAIL const_quad k=%0d got %0d want %0d", k, bus.quadrant, exp_quad(k)); end
            for (int j = 0; j < 5; j++) begin
                if (k == bk[j]) begin
                    checks++; if (int'(bus.sample) !== bv[j]) begin failures++; $display("FAIL const_point k=%0d got %0d want %0d", k, bus.sample, bv[j]); end
                end
            end
        end
        checks++; if (bus.period_cnt !== 16'd1) begin failures++; $display("FAIL const_period got %0d want 1", bus.period_cnt); end
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL const_running busy=%b done=%b want 1 0", bus.busy, bus.done); end
        $display("scenario const_rom ticks=%0d", PLEN);
    endtask

    task automatic test_real_rom();
        quiet_reset();
        load_rom(1);
        do_start();
        for (int k = 1; k <= 3 * PLEN; k++) begin
            checks++; if (int'(bus.rom_adrs) !== exp_adrs(k - 1)) begin failures++; $display("FAIL real_adrs k=%0d got %0d want %0d", k, bus.rom_adrs, exp_adrs(k - 1)); end
            pulse_tick();
            checks++; if (longint'(bus.sample) !== exp_sample(k)) begin failures++; $display("FAIL real_sample k=%0d got %0d want %0d", k, bus.sample, exp_sample(k)); end
            if (k % PLEN == QLEN) begin
                checks++; if (longint'(bus.sample) !== pref[QLEN]) begin failures++; $display("FAIL real_peak k=%0d got %0d want %0d", k, bus.sample, pref[QLEN]); end
            end
            if (k % PLEN == 3 * QLEN) begin
                checks++; if (longint'(bus.sample) !== -pref[QLEN]) begin failures++; $display("FAIL real_trough k=%0d got %0d want %0d", k, bus.sample, -pref[QLEN]); end
            end
            if (k % PLEN == 0) begin
                checks++; if (bus.sample !== '0 || int'(bus.period_cnt) !== k / PLEN) begin failures++; $display("FAIL real_period_end k=%0d sample=%0d period=%0d want 0 %0d", k, bus.sample, bus.period_cnt, k / PLEN); end
            end
        end
        checks++; if (bus.period_cnt !== 16'd3) begin failures++; $display("FAIL real_periods got %0d want 3", bus.period_cnt); end
        $display("scenario real_rom periods=3 peak=%0d", pref[QLEN]);
    endtask

    task automatic test_sparse_tick();
        quiet_reset();
        load_rom(2);
        do_start();
        for (int k = 1; k <= 600; k++) begin
            pulse_tick();
            checks++; if (bus.sample_vld !== 1'b1 || longint'(bus.sample) !== exp_sample(k)) begin failures++; $display("FAIL sparse_tick k=%0d vld=%b sample=%0d want 1 %0d", k, bus.sample_vld, bus.sample, exp_sample(k)); end
            for (int g = 0; g < 2; g++) begin
                cyc();
                checks++; if (bus.sample_vld !== 1'b0) begin failures++; $display("FAIL sparse_gap_vld k=%0d got %b want 0", k, bus.sample_vld); end
                checks++; if (longint'(bus.sample) !== exp_sample(k) || int'(bus.rom_adrs) !== exp_adrs(k)) begin failures++; $display("FAIL sparse_gap_hold k=%0d sample=%0d adrs=%0d want %0d %0d", k, bus.sample, bus.rom_adrs, exp_sample(k), exp_adrs(k)); end
            end
        end
        $display("scenario sparse_tick ticks=600 gap=2");
    endtask

    task automatic test_stop_mid();
        quiet_reset();
        load_rom(2);
        do_start();
        for (int k = 1; k <= PLEN; k++) begin
            if (k == 701) begin
                bus.stop = 1'b1;
                cyc();
                bus.stop = 1'b0;
            end
            repeat ($urandom_range(0, 2)) cyc();
            pulse_tick();
            checks++; if (longint'(bus.sample) !== exp_sample(k)) begin failures++; $display("FAIL stop_sample k=%0d got %0d want %0d", k, bus.sample, exp_sample(k)); end
            if (k < PLEN) begin
                checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL stop_early k=%0d done=%b busy=%b want 0 1", k, bus.done, bus.busy); end
            end
        end
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.sample_vld !== 1'b1) begin failures++; $display("FAIL stop_end done=%b busy=%b vld=%b want 1 0 1", bus.done, bus.busy, bus.sample_vld); end
        checks++; if (bus.period_cnt !== 16'd1 || bus.quadrant !== 2'd0) begin failures++; $display("FAIL stop_end_cnt period=%0d quad=%0d want 1 0", bus.period_cnt, bus.quadrant); end
        cyc();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL stop_done_pulse got %b want 0", bus.done); end
        for (int k = 0; k < 5; k++) begin
            pulse_tick();
            checks++; if (bus.sample_vld !== 1'b0 || bus.sample !== '0 || bus.rom_adrs !== '0 || bus.busy !== 1'b0) begin failures++; $display("FAIL stop_idle_tick vld=%b sample=%0d adrs=%0d busy=%b want 0 0 0 0", bus.sample_vld, bus.sample, bus.rom_adrs, bus.busy); end
        end
        $display("scenario stop_mid stop_at=700");
    endtask

    task automatic test_stop_at_end();
        quiet_reset();
        load_rom(2);
        do_start();
        for (int k = 1; k < PLEN; k++) begin
            pulse_tick();
            checks++; if (longint'(bus.sample) !== exp_sample(k)) begin failures++; $display("FAIL stopend_sample k=%0d got %0d want %0d", k, bus.sample, exp_sample(k)); end
        end
        pulse_tick(1'b1, 1'b0);
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.sample !== '0) begin failures++; $display("FAIL stopend_done done=%b busy=%b sample=%0d want 1 0 0", bus.done, bus.busy, bus.sample); end
        // start and stop together while idle: start wins, nothing pending
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.period_cnt !== 16'd0) begin failures++; $display("FAIL startstop_busy busy=%b period=%0d want 1 0", bus.busy, bus.period_cnt); end
        for (int k = 1; k <= PLEN + 1; k++) begin
            pulse_tick();
            checks++; if (longint'(bus.sample) !== exp_sample(k) || bus.done !== 1'b0) begin failures++; $display("FAIL startstop_run k=%0d sample=%0d done=%b want %0d 0", k, bus.sample, bus.done, exp_sample(k)); end
        end
        checks++; if (bus.busy !== 1'b1 || bus.period_cnt !== 16'd1) begin failures++; $display("FAIL startstop_cont busy=%b period=%0d want 1 1", bus.busy, bus.period_cnt); end
        $display("scenario stop_at_end and start_stop_idle");
    endtask

    task automatic test_reset_mid();
        quiet_reset();
        load_rom(2);
        do_start();
        for (int k = 1; k <= 1200; k++) pulse_tick();
        checks++; if (longint'(bus.sample) !== exp_sample(1200)) begin failures++; $display("FAIL rstmid_pre got %0d want %0d", bus.sample, exp_sample(1200)); end
        rst = 1'b1;
        bus.tick = 1'b1;
        cyc();
        rst = 1'b0;
        bus.tick = 1'b0;
        checks++; if (bus.sample !== '0 || bus.rom_adrs !== '0 || bus.sample_vld !== 1'b0 || bus.quadrant !== 2'd0) begin failures++; $display("FAIL rstmid_out sample=%0d adrs=%0d vld=%b quad=%0d want 0 0 0 0", bus.sample, bus.rom_adrs, bus.sample_vld, bus.quadrant); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.period_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_ctl busy=%b done=%b period=%0d want 0 0 0", bus.busy, bus.done, bus.period_cnt); end
        for (int k = 0; k < 4; k++) begin
            pulse_tick();
            checks++; if (bus.done !== 1'b0 || bus.sample_vld !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_after done=%b vld=%b busy=%b want 0 0 0", bus.done, bus.sample_vld, bus.busy); end
        end
        $display("scenario reset_mid at_tick=1200");
    endtask

    task automatic test_start_while_busy();
        quiet_reset();
        load_rom(2);
        do_start();
        for (int k = 1; k <= 700; k++) begin
            if (k == 300) begin
                bus.start = 1'b1;
                cyc();
                bus.start = 1'b0;
            end
            pulse_tick(1'b0, k == 100);
            checks++; if (longint'(bus.sample) !== exp_sample(k) || int'(bus.rom_adrs) !== exp_adrs(k)) begin failures++; $display("FAIL busystart k=%0d sample=%0d adrs=%0d want %0d %0d", k, bus.sample, bus.rom_adrs, exp_sample(k), exp_adrs(k)); end
        end
        $display("scenario start_while_busy ticks=700");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.tick  = 1'b0;
        test_reset();
        test_const_rom();
        test_real_rom();
        test_sparse_tick();
        test_stop_mid();
        test_stop_at_end();
        test_reset_mid();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
